// File: rtl/fht_frame_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : fht_frame_sched_if
//  Purpose  : Bundles the stream, bank-RAM and FHT-core signals of the frame
//             scheduler into one interface.
//  Modports : master - the scheduler (drives every o* signal)
//             slave  - the environment (drives every i* signal)
//  Signals  : input stream  iFRAME_START, iDATA, iDATA_VALID, oDATA_READY
//             bank writes   oWR_EN, oWR_BANK, oWR_ADDR, oWR_DATA
//             FHT core      oFHT_START, iFHT_RDY, iFHT_SOURCE, oRES_SET
//             bank reads    oRD_EN, oRD_BANK, oRD_ADDR, iRD_DATA
//             output stream oOUT_DATA, oOUT_VALID, iOUT_READY
//             status        oOWNER, oBUSY, oDONE, oERR, oFRAME_CNT
//  Revision : 1.0 - initial release
// ============================================================================
interface fht_frame_sched_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic             iFRAME_START;
  logic [D_BIT-1:0] iDATA;
  logic             iDATA_VALID;
  logic             oDATA_READY;
  logic             oWR_EN;
  logic [1:0]       oWR_BANK;
  logic [A_BIT-1:0] oWR_ADDR;
  logic [D_BIT-1:0] oWR_DATA;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             iFHT_SOURCE;
  logic             oRES_SET;
  logic             oRD_EN;
  logic [1:0]       oRD_BANK;
  logic [A_BIT-1:0] oRD_ADDR;
  logic [D_BIT-1:0] iRD_DATA;
  logic [D_BIT-1:0] oOUT_DATA;
  logic             oOUT_VALID;
  logic             iOUT_READY;
  logic [1:0]       oOWNER;
  logic             oBUSY;
  logic             oDONE;
  logic             oERR;
  logic [15:0]      oFRAME_CNT;

  modport master (
    input  iFRAME_START, iDATA, iDATA_VALID, iFHT_RDY, iFHT_SOURCE, iRD_DATA, iOUT_READY,
    output oDATA_READY, oWR_EN, oWR_BANK, oWR_ADDR, oWR_DATA, oFHT_START, oRES_SET,
           oRD_EN, oRD_BANK, oRD_ADDR, oOUT_DATA, oOUT_VALID, oOWNER, oBUSY, oDONE,
           oERR, oFRAME_CNT
  );

  modport slave (
    output iFRAME_START, iDATA, iDATA_VALID, iFHT_RDY, iFHT_SOURCE, iRD_DATA, iOUT_READY,
    input  oDATA_READY, oWR_EN, oWR_BANK, oWR_ADDR, oWR_DATA, oFHT_START, oRES_SET,
           oRD_EN, oRD_BANK, oRD_ADDR, oOUT_DATA, oOUT_VALID, oOWNER, oBUSY, oDONE,
           oERR, oFRAME_CNT
  );
endinterface
`default_nettype wire

// File: rtl/fht_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fht_frame_sched
//  Purpose  : Frame-level sequencer around the FHT core and its 4-bank RAM.
//             Loads one N = 4<<A_BIT point frame from a valid/ready stream,
//             kicks the core, waits for completion (with timeout), then
//             streams the result out through a 2-entry FIFO with
//             backpressure. Drives the bank-ownership select.
//  Ports    : iCLK   - clock
//             iRESET - synchronous reset, active-high
//             bus    - fht_frame_sched_if.master (stream, bank RAM, core,
//                      status signals)
//  Revision : 1.0 - initial release
// ============================================================================
module fht_frame_sched #(
  parameter int A_BIT   = 8,
  parameter int D_BIT   = 16,
  parameter int TIMEOUT = 4096
) (
  input  wire logic           iCLK,
  input  wire logic           iRESET,
  fht_frame_sched_if.master   bus
);

  localparam int              N          = 4 << A_BIT;
  localparam int              KW         = A_BIT + 3;   // holds 0..N
  localparam logic [KW-1:0]   C_LAST     = KW'(N - 1);
  localparam logic [KW-1:0]   C_N        = KW'(N);
  localparam logic [15:0]     C_TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KICK   = 3'd2,
    S_RUN    = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;              // load index / unload read-issue index
  logic [KW-1:0]    out_cnt_q, out_cnt_d;  // samples popped during unload
  logic [15:0]      tmo_q, tmo_d;          // RUN cycles already elapsed
  logic             seen_busy_q, seen_busy_d;
  logic             res_set_q, res_set_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             inflight_q, inflight_d;
  logic [D_BIT-1:0] fifo_q [2];
  logic [D_BIT-1:0] fifo_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_occ_after;
  logic             w_rd_en;

  assign w_accept = (state_q == S_LOAD) && bus.iDATA_VALID;
  assign w_push   = inflight_q;
  assign w_pop    = (cnt_q != 2'd0) && bus.iOUT_READY;

  // Occupancy after this cycle's pop, counting the read still in flight.
  // Crediting the pop here is what lets the 2-entry FIFO sustain one sample
  // per cycle: otherwise a full pipeline would stall every third cycle.
  assign w_occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_rd_en     = (state_q == S_UNLOAD) && (w_occ_after < 3'd2) && (k_q < C_N);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      out_cnt_q   <= '0;
      tmo_q       <= '0;
      seen_busy_q <= 1'b0;
      res_set_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_cnt_q   <= out_cnt_d;
      tmo_q       <= tmo_d;
      seen_busy_q <= seen_busy_d;
      res_set_q   <= res_set_d;
      err_q       <= err_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      inflight_q  <= inflight_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_cnt_d   = out_cnt_q;
    tmo_d       = tmo_q;
    seen_busy_d = seen_busy_q;
    res_set_d   = res_set_q;
    err_d       = err_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    inflight_d  = w_rd_en;
    fifo_d[0]   = fifo_q[0];
    fifo_d[1]   = fifo_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, w_push} - {1'b0, w_pop};

    // Read data returns exactly one cycle after the request.
    if (w_push) begin
      fifo_d[wr_ptr_q] = bus.iRD_DATA;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.iFRAME_START) begin
          state_d   = S_LOAD;
          k_d       = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          k_d = k_q + 1'b1;
          if (k_q == C_LAST) begin
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        seen_busy_d = 1'b0;
        tmo_d       = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (!bus.iFHT_RDY) begin
          seen_busy_d = 1'b1;
        end
        // Ready only counts as completion once the core has been seen busy;
        // it is still high from its idle state right after the start pulse.
        if (seen_busy_q && bus.iFHT_RDY) begin
          res_set_d = bus.iFHT_SOURCE;
          k_d       = '0;
          out_cnt_d = '0;
          state_d   = S_UNLOAD;
        end else if (tmo_q >= C_TMO_LAST) begin
          // This is the TIMEOUT-th cycle spent in RUN.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_UNLOAD: begin
        if (w_rd_en) begin
          k_d = k_q + 1'b1;
        end
        if (w_pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == C_LAST) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case (state_q)
      S_KICK, S_RUN: bus.oOWNER = 2'd1;
      S_UNLOAD:      bus.oOWNER = 2'd2;
      default:       bus.oOWNER = 2'd0;
    endcase
  end

  assign bus.oDATA_READY = (state_q == S_LOAD);
  assign bus.oWR_EN      = w_accept;
  assign bus.oWR_BANK    = w_accept ? k_q[1:0] : 2'd0;
  assign bus.oWR_ADDR    = w_accept ? k_q[A_BIT+1:2] : '0;
  assign bus.oWR_DATA    = w_accept ? bus.iDATA : '0;
  assign bus.oFHT_START  = (state_q == S_KICK);
  assign bus.oRES_SET    = res_set_q;
  assign bus.oRD_EN      = w_rd_en;
  assign bus.oRD_BANK    = w_rd_en ? k_q[1:0] : 2'd0;
  assign bus.oRD_ADDR    = w_rd_en ? k_q[A_BIT+1:2] : '0;
  assign bus.oOUT_VALID  = (cnt_q != 2'd0);
  assign bus.oOUT_DATA   = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign bus.oBUSY       = (state_q != S_IDLE);
  assign bus.oDONE       = done_q;
  assign bus.oERR        = err_q;
  assign bus.oFRAME_CNT  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fht_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fht_frame_sched
//  Purpose  : Directed self-checking bench for fht_frame_sched. A behavioural
//             4-bank RAM sits on the write/read ports; the FHT core handshake
//             and both streams are driven step by step from one initial block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fht_frame_sched;

  localparam int A_BIT   = 8;
  localparam int D_BIT   = 16;
  localparam int TIMEOUT = 4096;
  localparam int N       = 4 << A_BIT;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [D_BIT-1:0] exp_data [N];
  logic [D_BIT-1:0] ram [4][1 << A_BIT];

  fht_frame_sched_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_frame_sched #(
    .A_BIT   (A_BIT),
    .D_BIT   (D_BIT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank RAM: synchronous write, read data valid the cycle after oRD_EN.
  always @(posedge clk) begin
    if (bus.oWR_EN) ram[bus.oWR_BANK][bus.oWR_ADDR] <= bus.oWR_DATA;
    if (bus.oRD_EN) bus.iRD_DATA <= ram[bus.oRD_BANK][bus.oRD_ADDR];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    bus.iFRAME_START = 1'b1;
    tick();
    bus.iFRAME_START = 1'b0;
  endtask

  // Streams N samples (data = k ^ mask); valid either constant or toggling.
  task automatic load_frame(input bit toggle, input logic [15:0] mask);
    int k   = 0;
    int cyc = 0;
    logic [15:0] d;
    while (k < N && cyc < 3 * N) begin
      d = 16'(k) ^ mask;
      bus.iDATA_VALID = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.iDATA       = d;
      #1;
      if (bus.iDATA_VALID) begin
        chk("load_write", 32'({bus.oWR_EN, bus.oWR_BANK, bus.oWR_ADDR, bus.oWR_DATA}),
            32'({1'b1, 2'(k % 4), 8'(k / 4), d}));
        exp_data[k] = d;
        k++;
      end else begin
        chk("load_idle_wr_en", 32'(bus.oWR_EN), 32'd0);
      end
      tick();
      cyc++;
    end
    bus.iDATA_VALID = 1'b0;
    chk("load_count", 32'(k), 32'(N));
    if (toggle) chk("load_toggle_cycles", 32'(cyc), 32'(2 * N - 1));
    // Now in KICK
    chk("kick_start", 32'(bus.oFHT_START), 32'd1);
    chk("kick_owner_ready", 32'({bus.oOWNER, bus.oDATA_READY}), 32'({2'd1, 1'b0}));
  endtask

  // Called in the first RUN cycle. Core ready stays high hi_cyc cycles,
  // low for lo_cyc, then rises with the given result set.
  task automatic run_core(input int hi_cyc, input int lo_cyc, input logic src,
                          input bit poke_start);
    for (int i = 0; i < hi_cyc; i++) begin
      chk("run_premature_done", 32'({bus.oOWNER, bus.oFHT_START}), 32'({2'd1, 1'b0}));
      tick();
    end
    bus.iFHT_RDY = 1'b0;
    for (int i = 0; i < lo_cyc; i++) begin
      bus.iFRAME_START = poke_start && (i == 2);
      tick();
    end
    bus.iFRAME_START = 1'b0;
    if (poke_start)
      chk("start_in_run_ignored", 32'({bus.oOWNER, bus.oDATA_READY, bus.oBUSY}),
          32'({2'd1, 1'b0, 1'b1}));
    bus.iFHT_RDY    = 1'b1;
    bus.iFHT_SOURCE = src;
    tick();
    chk("unload_owner", 32'(bus.oOWNER), 32'd2);
    chk("res_set", 32'(bus.oRES_SET), 32'(src));
    bus.iFHT_SOURCE = ~src;
  endtask

  // Called in the first UNLOAD cycle; pops up to stop_at samples in order.
  task automatic unload_frame(input bit rnd, input int stop_at, output int cycles);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_at && cyc < 8 * N) begin
      bus.iOUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.oOUT_VALID && bus.iOUT_READY) begin
        chk("unload_data", 32'(bus.oOUT_DATA), 32'(exp_data[idx]));
        idx++;
      end
      tick();
      cyc++;
    end
    bus.iOUT_READY = 1'b0;
    chk("unload_count", 32'(idx), 32'(stop_at));
    cycles = cyc;
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    rst              = 1'b1;
    bus.iFRAME_START = 1'b0;
    bus.iDATA        = '0;
    bus.iDATA_VALID  = 1'b0;
    bus.iFHT_RDY     = 1'b1;
    bus.iFHT_SOURCE  = 1'b0;
    bus.iOUT_READY   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy_ready", 32'({bus.oBUSY, bus.oDATA_READY}), 32'd0);
    chk("rst_owner_resset", 32'({bus.oOWNER, bus.oRES_SET}), 32'd0);
    chk("rst_err_done_valid", 32'({bus.oERR, bus.oDONE, bus.oOUT_VALID}), 32'd0);
    chk("rst_frame_cnt", 32'(bus.oFRAME_CNT), 32'd0);
    chk("rst_strobes", 32'({bus.oWR_EN, bus.oRD_EN, bus.oFHT_START}), 32'd0);

    // Frame 1: data = k, valid always, result in set 1, ready always
    start_frame();
    chk("load_state", 32'({bus.oBUSY, bus.oDATA_READY, bus.oOWNER}), 32'({1'b1, 1'b1, 2'd0}));
    load_frame(1'b0, 16'h0000);
    tick();
    run_core(4, 300, 1'b1, 1'b0);
    unload_frame(1'b0, N, cyc);
    chk("unload_throughput", 32'(cyc >= N + 2 && cyc <= N + 4), 32'd1);
    chk("done_pulse", 32'(bus.oDONE), 32'd1);
    chk("frame_cnt_1", 32'(bus.oFRAME_CNT), 32'd1);
    chk("idle_after_frame", 32'({bus.oBUSY, bus.oOWNER}), 32'd0);
    chk("res_set_held", 32'(bus.oRES_SET), 32'd1);
    tick();
    chk("done_single", 32'(bus.oDONE), 32'd0);

    // Frame 2: toggling valid, random backpressure, result in set 0,
    // a start pulse during RUN
    start_frame();
    load_frame(1'b1, 16'hA5A5);
    tick();
    run_core(2, 10, 1'b0, 1'b1);
    unload_frame(1'b1, N, cyc);
    chk("done_pulse_2", 32'(bus.oDONE), 32'd1);
    chk("frame_cnt_2", 32'(bus.oFRAME_CNT), 32'd2);
    chk("res_set_2", 32'(bus.oRES_SET), 32'd0);
    tick();

    // Frame 3: core never finishes -> timeout after TIMEOUT RUN cycles
    start_frame();
    load_frame(1'b0, 16'h0F0F);
    bus.iFHT_RDY = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", 32'({bus.oBUSY, bus.oERR, bus.oOWNER}), 32'({1'b1, 1'b0, 2'd1}));
    tick();
    chk("tmo_err_idle", 32'({bus.oERR, bus.oBUSY, bus.oDONE}), 32'({1'b1, 1'b0, 1'b0}));
    chk("tmo_frame_cnt", 32'(bus.oFRAME_CNT), 32'd2);
    tick();
    chk("tmo_err_sticky", 32'(bus.oERR), 32'd1);
    bus.iFHT_RDY = 1'b1;
    start_frame();
    chk("err_cleared_on_start", 32'({bus.oERR, bus.oDATA_READY}), 32'({1'b0, 1'b1}));

    // Frame 4: reset in the middle of unload
    load_frame(1'b0, 16'hFFFF);
    tick();
    run_core(2, 8, 1'b1, 1'b0);
    unload_frame(1'b0, 500, cyc);
    rst = 1'b1;
    tick();
    chk("midrst_idle", 32'({bus.oBUSY, bus.oOUT_VALID, bus.oDONE, bus.oRD_EN}), 32'd0);
    chk("midrst_cnt_owner", 32'({bus.oFRAME_CNT, bus.oOWNER, bus.oRES_SET}), 32'd0);
    rst = 1'b0;
    bus.iOUT_READY = 1'b1;
    tick();
    chk("after_rst_quiet", 32'({bus.oBUSY, bus.oOUT_VALID, bus.oDONE}), 32'd0);
    tick();
    chk("after_rst_quiet_2", 32'({bus.oOUT_VALID, bus.oDONE, bus.oFRAME_CNT}), 32'd0);
    bus.iOUT_READY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
